// File: rtl/core_bus_adapter.sv
// Queues core requests in a small FIFO and replays each as a level-held mem_read/mem_write
// strobe with a bounded wait. Optional counters behind CORE_BUS_ADAPTER_STATS_EN.
module core_bus_adapter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  flush,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_response,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
`ifdef CORE_BUS_ADAPTER_STATS_EN
  ,
  output logic [15:0]           stat_reads,
  output logic [15:0]           stat_writes,
  output logic [15:0]           stat_timeouts
`endif
);

  localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata_q [FIFO_DEPTH];
  logic                  fifo_we_q    [FIFO_DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  req_ready_q, req_ready_d;
  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic empty, full_d, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // Flush drops both the same-cycle push and any pop of a queued entry.
  assign push  = req_valid && req_ready_q && !flush;
  assign pop   = (state_q == StIdle) && !empty && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PtrW'(push);
    rd_ptr_d    = flush ? wr_ptr_q : rd_ptr_q + PtrW'(pop);
    full_d      = (wr_ptr_d[PtrW-1] != rd_ptr_d[PtrW-1]) &&
                  (wr_ptr_d[IdxW-1:0] == rd_ptr_d[IdxW-1:0]);
    req_ready_d = !full_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[IdxW-1:0]]  <= req_addr;
      fifo_wdata_q[wr_ptr_q[IdxW-1:0]] <= req_wdata;
      fifo_we_q[wr_ptr_q[IdxW-1:0]]    <= req_we;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          we_d    = fifo_we_q[rd_ptr_q[IdxW-1:0]];
          addr_d  = fifo_addr_q[rd_ptr_q[IdxW-1:0]];
          wdata_d = fifo_wdata_q[rd_ptr_q[IdxW-1:0]];
          cnt_d   = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        cnt_d = cnt_q + CntW'(1);
        // A response in the timeout cycle still counts as a normal completion.
        if (mem_response) begin
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : mem_read_data;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_ready_q <= 1'b1;
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_ready_q <= req_ready_d;
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign mem_read       = (state_q == StActive) && !we_q;
  assign mem_write      = (state_q == StActive) && we_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign rsp_valid      = (state_q == StResp);
  assign rsp_write      = rsp_valid && we_q;
  assign rsp_err        = rsp_valid && err_q;
  assign rsp_rdata      = rdata_q;
  assign busy           = !empty || (state_q != StIdle);

`ifdef CORE_BUS_ADAPTER_STATS_EN
  logic [15:0] reads_q, reads_d, writes_q, writes_d, tmo_q, tmo_d;

  always_comb begin
    reads_d  = reads_q;
    writes_d = writes_q;
    tmo_d    = tmo_q;
    if (state_q == StResp) begin
      if (err_q) begin
        if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
      end else if (we_q) begin
        if (writes_q != 16'hFFFF) writes_d = writes_q + 16'd1;
      end else begin
        if (reads_q != 16'hFFFF) reads_d = reads_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reads_q  <= '0;
      writes_q <= '0;
      tmo_q    <= '0;
    end else begin
      reads_q  <= reads_d;
      writes_q <= writes_d;
      tmo_q    <= tmo_d;
    end
  end

  assign stat_reads    = reads_q;
  assign stat_writes   = writes_q;
  assign stat_timeouts = tmo_q;
`endif

endmodule

// File: tb/tb_core_bus_adapter.sv
// Randomized scoreboard bench for core_bus_adapter: a queue-level request model, a randomly
// delayed memory responder, and an independent response monitor.
module tb_core_bus_adapter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, flush = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, mem_read_data = '0;
  logic          mem_response = 1'b0;
  logic          req_ready, rsp_valid, rsp_write, rsp_err, mem_read, mem_write, busy;
  logic [DW-1:0] rsp_rdata, mem_write_data;
  logic [AW-1:0] mem_address;

  core_bus_adapter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .flush(flush), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_response(mem_response), .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_t;
  typedef struct packed {logic we; logic err; logic [DW-1:0] rdata;} rsp_t;

  req_t          model_q[$];
  rsp_t          exp_q[$];
  int            total = 0, bad = 0;
  req_t          cur, pend_req;
  logic          push_pend = 0, flush_pend = 0, prev_strobe = 0, force_stall = 0;
  int            lat = 0, act_len = 0, exp_len = 0;
  logic [DW-1:0] rd_val = '0, last_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (!reset) begin
      last_rdata = '0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_write", 64'(rsp_write), 64'(e.we));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        last_rdata = e.rdata;
      end
    end else begin
      check("rsp_rdata_hold", 64'(rsp_rdata), 64'(last_rdata));
    end
  end

  // One clock cycle: account for the last edge, check, then drive the next cycle's inputs.
  task automatic cycle(input int vprob, input bit flush_en);
    logic strobe, err;
    @(negedge clk);
    if (flush_pend) model_q.delete();
    else if (push_pend) model_q.push_back(pend_req);
    strobe = mem_read | mem_write;
    check("strobe_onehot", 64'(mem_read & mem_write), 64'(0));
    if (strobe && !prev_strobe) begin
      act_len = 0;
      if (model_q.size() == 0) begin
        check("issue_without_request", 64'(1), 64'(0));
      end else begin
        cur = model_q.pop_front();
        check("issue_dir", 64'(mem_write), 64'(cur.we));
        check("issue_addr", 64'(mem_address), 64'(cur.addr));
        if (cur.we) check("issue_wdata", 64'(mem_write_data), 64'(cur.wdata));
        lat     = force_stall ? 1000 : $urandom_range(0, 11);
        rd_val  = $urandom;
        err     = (lat > TO - 1);
        exp_len = err ? TO : lat + 1;
        exp_q.push_back('{we: cur.we, err: err, rdata: (cur.we || err) ? '0 : rd_val});
      end
    end else if (strobe) begin
      check("hold_addr", 64'(mem_address), 64'(cur.addr));
      check("hold_dir", 64'(mem_write), 64'(cur.we));
      if (cur.we) check("hold_wdata", 64'(mem_write_data), 64'(cur.wdata));
    end
    if (strobe) act_len++;
    if (!strobe && prev_strobe) check("active_len", 64'(act_len), 64'(exp_len));
    check("rsp_timing", 64'(rsp_valid), 64'(!strobe && prev_strobe));
    check("req_ready", 64'(req_ready), 64'(model_q.size() < DEPTH));
    check("busy", 64'(busy), 64'(model_q.size() != 0 || strobe || rsp_valid));
    prev_strobe = strobe;
    if (strobe) begin
      mem_response  = (act_len - 1 == lat);
      mem_read_data = mem_response ? rd_val : $urandom;
    end else begin
      mem_response  = ($urandom_range(0, 3) == 0);
      mem_read_data = $urandom;
    end
    req_valid  = ($urandom_range(0, 3) < vprob);
    flush      = flush_en && ($urandom_range(0, 29) == 0);
    req_we     = $urandom_range(0, 1) == 1;
    req_addr   = $urandom & ~32'h3;
    req_wdata  = $urandom;
    pend_req   = '{we: req_we, addr: req_addr, wdata: req_wdata};
    push_pend  = req_valid && req_ready && !flush;
    flush_pend = flush;
  endtask

  initial begin
    bit drained;
    #1 reset = 1'b0;
    #2;
    check("reset_req_ready", 64'(req_ready), 64'(1));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_strobes", 64'({mem_read, mem_write}), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_rdata", 64'(rsp_rdata), 64'(0));
    check("reset_addr", 64'(mem_address), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Stalled controller with continuous requests: queue fills and req_ready drops.
    force_stall = 1'b1;
    repeat (60) cycle(4, 1'b0);
    force_stall = 1'b0;

    repeat (3000) cycle($urandom_range(1, 3), 1'b1);

    drained = 1'b0;
    for (int i = 0; i < 3000 && !drained; i++) begin
      cycle(0, 1'b0);
      drained = (model_q.size() == 0) && (exp_q.size() == 0) && !busy && !prev_strobe;
    end
    check("drain_complete", 64'(drained), 64'(1));

    // Reset asserted while a read is active.
    force_stall = 1'b1;
    req_valid   = 1'b1;
    req_we      = 1'b0;
    req_addr    = 32'h10;
    pend_req    = '{we: 1'b0, addr: 32'h10, wdata: req_wdata};
    push_pend   = req_ready;
    flush_pend  = 1'b0;
    for (int i = 0; i < 10 && !prev_strobe; i++) cycle(0, 1'b0);
    check("reset_test_active", 64'(mem_read), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("async_mem_read", 64'(mem_read), 64'(0));
    check("async_rsp_valid", 64'(rsp_valid), 64'(0));
    check("async_req_ready", 64'(req_ready), 64'(1));
    check("async_busy", 64'(busy), 64'(0));
    model_q.delete();
    exp_q.delete();
    prev_strobe = 1'b0;
    push_pend   = 1'b0;
    flush_pend  = 1'b0;
    force_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) cycle(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
